elevator_scheduler: RTL and testbench
=====================================

# elevator_scheduler

Request scheduler and car-position controller for the three-floor elevator. It latches floor calls from the three floor buttons and serves them in SCAN order (continue in the current direction while calls remain ahead, then reverse). It times floor-to-floor travel and door dwell, and handles overload and SOS. It runs on the divided `clk` produced by the frequency divisor. Its `current_floor`, `move_up` and `move_down` outputs drive the movement/LED logic in `top`.

## Interface

Parameters:
- `TRAVEL_TICKS`, default 2: `clk` cycles to travel one floor; must be ≥1.
- `DOOR_TICKS`, default 3: `clk` cycles the door stays open with no load hold; must be ≥1.

Ports:
- `clk` input 1: divided system clock; all state updates on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `st_button`, `nd_button`, `rd_button` input 1 each: floor calls for floors 00, 01 and 10. Level inputs, sampled every cycle.
- `sos_button` input 1: emergency request; only its rising edge acts.
- `weight_sensor` input 1: high means the car is overloaded.
- `current_floor` output 2: 00, 01 or 10; 11 never occurs.
- `move_up`, `move_down` output 1 each: car in transit; at most one is high.
- `door_open` output 1: door open at `current_floor`.
- `pending` output 3: latched calls; bit i is floor i; drives the floor LEDs.
- `emergency` output 1: high while in EMERGENCY.
- `overload` output 1: `weight_sensor` is high while in DOOR_OPEN.

## Operation

State and outputs:
- States: IDLE, MOVING, DOOR_OPEN, EMERGENCY. Registers: `state`, `dir` (up/down), `travel_cnt`, `door_cnt`, `pending`, `current_floor`, and the previous `sos_button` sample.
- All outputs decode from registered state only (Moore).
- Reset values: state IDLE, `current_floor`=00, `pending`=000, `dir`=up, both counters 0, previous sos sample 0. Every output is 0.

Call latching:
- Each cycle, `pending[i]` is set if its button is high.
- A call for `current_floor` is ignored while in DOOR_OPEN.
- All calls are ignored while in EMERGENCY.
- "Ahead" means pending calls strictly above the car (dir up) or strictly below it (dir down).

IDLE:
- If `pending[current_floor]` is set, go to DOOR_OPEN.
- Otherwise, if calls exist ahead in `dir`, go to MOVING in `dir`.
- Otherwise, if calls exist behind, invert `dir` and go to MOVING.
- Otherwise, stay in IDLE.

MOVING:
- `travel_cnt` increments every cycle.
- When `travel_cnt`==TRAVEL_TICKS-1:
  - `current_floor` steps ±1 and `travel_cnt` clears to 0.
  - If `pending[new floor]` is set, go to DOOR_OPEN on the same edge. Otherwise keep moving; a call further ahead is guaranteed to exist.

DOOR_OPEN:
- On the entry edge, `pending[current_floor]` clears and `door_cnt` clears to 0.
- While `weight_sensor` is high, `door_cnt` is held at 0, so the door cannot close.
- Otherwise `door_cnt` increments.
- When `door_cnt`==DOOR_TICKS-1 and `weight_sensor` is low, apply the IDLE direction rules. With no calls remaining, go to IDLE.

EMERGENCY:
- A rising edge of `sos_button` in any other state enters EMERGENCY on the next edge.
- Entry clears `pending` and both counters. `current_floor` keeps the last floor reached; a partial transit is discarded.
- A second rising edge of `sos_button` exits to IDLE.

Boundary rules:
- The SOS edge has top priority. A button press on the same cycle as the SOS edge is discarded.
- Exactly one of `move_up`/`move_down` is high in MOVING; both are 0 elsewhere.
- The car never steps above floor 10 or below 00, since MOVING only starts toward an existing call.
- Reset asserted mid-transit or mid-dwell returns all state to the reset values immediately.

## Timing

- Button-to-`pending` latency: 1 edge.
- `pending`-to-MOVING latency: 1 edge.
- One floor takes exactly TRAVEL_TICKS cycles. `current_floor` and `door_open` change on the same edge at a called floor.
- Door dwell is DOOR_TICKS cycles after the last cycle with `weight_sensor` high.
- SOS: EMERGENCY is entered 1 edge after the `sos_button` rising edge is sampled.
- Asynchronous reset takes effect immediately; there is no other combinational input-to-output path.

## Test plan

1. Reset, then pulse `rd_button` for 1 cycle → `pending`=100. `move_up` is high 2 edges after the press. `current_floor`=01 TRAVEL_TICKS cycles later and 10 after 2·TRAVEL_TICKS; `door_open` rises on that same edge. `pending`=000, door open for 3 cycles, then IDLE.
2. Car at 00, press `st_button` → DOOR_OPEN next edge, no movement, `pending` stays 000.
3. Car moving up from 00 toward 10, press `nd_button` before arrival at 01 → stops at 01 with door open, then continues to 10. SCAN order is preserved.
4. Car at 10, calls pending at 00 and 01, `dir`=up → `dir` inverts, stops at 01, then 00; `move_down` only.
5. Door open with `weight_sensor` held high for 10 cycles → `overload`=1 and the door stays open throughout. It closes 3 cycles after `weight_sensor` falls.
6. SOS mid-transit between 00 and 01 → `emergency`=1, movement stops, `current_floor`=00, `pending`=000, buttons ignored. A second SOS edge returns to IDLE.

Source files
------------

// File: rtl/elevator_scheduler.sv
// Three-floor elevator scheduler: latches floor calls, serves them in SCAN order,
// times travel and door dwell, and handles overload hold and SOS.
module elevator_scheduler #(
    parameter int unsigned TRAVEL_TICKS = 2,
    parameter int unsigned DOOR_TICKS   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       st_button,
    input  logic       nd_button,
    input  logic       rd_button,
    input  logic       sos_button,
    input  logic       weight_sensor,
    output logic [1:0] current_floor,
    output logic       move_up,
    output logic       move_down,
    output logic       door_open,
    output logic [2:0] pending,
    output logic       emergency,
    output logic       overload
);

    localparam int unsigned TravelW = (TRAVEL_TICKS > 1) ? $clog2(TRAVEL_TICKS) : 1;
    localparam int unsigned DoorW   = (DOOR_TICKS > 1) ? $clog2(DOOR_TICKS) : 1;
    localparam logic [TravelW-1:0] TravelLast = TravelW'(TRAVEL_TICKS - 1);
    localparam logic [DoorW-1:0]   DoorLast   = DoorW'(DOOR_TICKS - 1);

    typedef enum logic [1:0] {StIdle, StMoving, StDoorOpen, StEmergency} state_e;

    state_e             state;
    logic               dir;  // 1 = up
    logic [TravelW-1:0] travel_cnt;
    logic [DoorW-1:0]   door_cnt;
    logic               sos_prev;
    logic               overload_q;

    logic       sos_rise;
    logic [2:0] buttons, calls, merged;
    logic [2:0] here_mask, above_mask, below_mask, step_mask;
    logic [2:0] ahead, behind;
    logic [1:0] step_floor;

    always_comb begin
        case (current_floor)
            2'd0: begin
                here_mask  = 3'b001;
                above_mask = 3'b110;
                below_mask = 3'b000;
            end
            2'd1: begin
                here_mask  = 3'b010;
                above_mask = 3'b100;
                below_mask = 3'b001;
            end
            default: begin
                here_mask  = 3'b100;
                above_mask = 3'b000;
                below_mask = 3'b011;
            end
        endcase
        sos_rise = sos_button & ~sos_prev;
        buttons  = {rd_button, nd_button, st_button};
        calls    = buttons;
        if (state == StEmergency || sos_rise) begin
            calls = 3'b000;
        end else if (state == StDoorOpen) begin
            calls = buttons & ~here_mask;
        end
        merged     = pending | calls;
        ahead      = dir ? (pending & above_mask) : (pending & below_mask);
        behind     = dir ? (pending & below_mask) : (pending & above_mask);
        step_floor = dir ? current_floor + 2'd1 : current_floor - 2'd1;
        step_mask  = 3'b001 << step_floor;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            dir           <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
            pending       <= 3'b000;
            current_floor <= 2'd0;
            sos_prev      <= 1'b0;
            overload_q    <= 1'b0;
        end else begin
            sos_prev   <= sos_button;
            pending    <= merged;
            overload_q <= 1'b0;
            if (state != StEmergency && sos_rise) begin
                state      <= StEmergency;
                pending    <= 3'b000;
                travel_cnt <= '0;
                door_cnt   <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        // A call at the car's own floor opens the door without being latched.
                        if ((merged & here_mask) != 3'b000) begin
                            state      <= StDoorOpen;
                            pending    <= merged & ~here_mask;
                            door_cnt   <= '0;
                            overload_q <= weight_sensor;
                        end else if (ahead != 3'b000) begin
                            state      <= StMoving;
                            travel_cnt <= '0;
                        end else if (behind != 3'b000) begin
                            dir        <= ~dir;
                            state      <= StMoving;
                            travel_cnt <= '0;
                        end
                    end
                    StMoving: begin
                        if (travel_cnt == TravelLast) begin
                            current_floor <= step_floor;
                            travel_cnt    <= '0;
                            if ((merged & step_mask) != 3'b000) begin
                                state      <= StDoorOpen;
                                pending    <= merged & ~step_mask;
                                door_cnt   <= '0;
                                overload_q <= weight_sensor;
                            end
                        end else begin
                            travel_cnt <= travel_cnt + TravelW'(1);
                        end
                    end
                    StDoorOpen: begin
                        if (weight_sensor) begin
                            door_cnt   <= '0;
                            overload_q <= 1'b1;
                        end else if (door_cnt == DoorLast) begin
                            travel_cnt <= '0;
                            if (ahead != 3'b000) begin
                                state <= StMoving;
                            end else if (behind != 3'b000) begin
                                dir   <= ~dir;
                                state <= StMoving;
                            end else begin
                                state <= StIdle;
                            end
                        end else begin
                            door_cnt <= door_cnt + DoorW'(1);
                        end
                    end
                    StEmergency: begin
                        if (sos_rise) begin
                            state <= StIdle;
                        end
                    end
                endcase
            end
        end
    end

    assign move_up   = (state == StMoving) && dir;
    assign move_down = (state == StMoving) && !dir;
    assign door_open = (state == StDoorOpen);
    assign emergency = (state == StEmergency);
    assign overload  = overload_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: per-cycle vector table routed through a scoreboard
// queue, plus hand-written asynchronous reset sequences.
module tb_elevator_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       st_button, nd_button, rd_button, sos_button, weight_sensor;
    logic [1:0] current_floor;
    logic       move_up, move_down, door_open, emergency, overload;
    logic [2:0] pending;
    logic [9:0] obs;

    always #5 clk = ~clk;

    elevator_scheduler #(
        .TRAVEL_TICKS(2),
        .DOOR_TICKS  (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .st_button    (st_button),
        .nd_button    (nd_button),
        .rd_button    (rd_button),
        .sos_button   (sos_button),
        .weight_sensor(weight_sensor),
        .current_floor(current_floor),
        .move_up      (move_up),
        .move_down    (move_down),
        .door_open    (door_open),
        .pending      (pending),
        .emergency    (emergency),
        .overload     (overload)
    );

    // {floor[1:0], up, down, door, pending[2:0], emergency, overload}
    assign obs = {current_floor, move_up, move_down, door_open, pending, emergency, overload};

    typedef struct {
        string      name;
        logic [4:0] in;   // {st, nd, rd, sos, weight}
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got fl/up/dn/door/pend/em/ov=%b_%b%b%b_%b_%b%b want %b_%b%b%b_%b_%b%b",
                     name, act[9:8], act[7], act[6], act[5], act[4:2], act[1], act[0],
                     exp[9:8], exp[7], exp[6], exp[5], exp[4:2], exp[1], exp[0]);
        end
    endtask

    // mv = {up, down, door}
    task automatic add(input string n, input logic [4:0] i, input logic [1:0] f,
                       input logic [2:0] mv, input logic [2:0] p, input logic em,
                       input logic ov);
        vec_t v;
        v.name = n;
        v.in   = i;
        v.exp  = {f, mv, p, em, ov};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [4:0] i);
        {st_button, nd_button, rd_button, sos_button, weight_sensor} = i;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(5'b00000);

        // Pulse rd from floor 00: travel two floors, dwell three cycles.
        add("t1_press",   5'b00100, 2'd0, 3'b000, 3'b100, 1'b0, 1'b0);
        add("t1_start",   5'b00000, 2'd0, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t1_trav0",   5'b00000, 2'd0, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t1_fl1",     5'b00000, 2'd1, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t1_trav1",   5'b00000, 2'd1, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t1_arrive",  5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t1_dwell1",  5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t1_dwell2",  5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t1_close",   5'b00000, 2'd2, 3'b000, 3'b000, 1'b0, 1'b0);
        // At 10 with dir up, calls at 00 and 01: reverse, stop at 01 then 00.
        add("t4_calls",   5'b11000, 2'd2, 3'b000, 3'b011, 1'b0, 1'b0);
        add("t4_start",   5'b00000, 2'd2, 3'b010, 3'b011, 1'b0, 1'b0);
        add("t4_trav",    5'b00000, 2'd2, 3'b010, 3'b011, 1'b0, 1'b0);
        add("t4_stop1",   5'b00000, 2'd1, 3'b001, 3'b001, 1'b0, 1'b0);
        add("t4_dwell1",  5'b00000, 2'd1, 3'b001, 3'b001, 1'b0, 1'b0);
        add("t4_dwell2",  5'b00000, 2'd1, 3'b001, 3'b001, 1'b0, 1'b0);
        add("t4_resume",  5'b00000, 2'd1, 3'b010, 3'b001, 1'b0, 1'b0);
        add("t4_trav2",   5'b00000, 2'd1, 3'b010, 3'b001, 1'b0, 1'b0);
        add("t4_stop0",   5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t4_dwell3",  5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t4_dwell4",  5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t4_close",   5'b00000, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        // Call at the car's own floor opens immediately; repeat press while open ignored.
        add("t2_press",   5'b10000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t2_ignore",  5'b10000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t2_dwell",   5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t2_close",   5'b00000, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        // dir is down at 00: rd reverses it; nd pressed in transit stops the car at 01.
        add("t3_press",   5'b00100, 2'd0, 3'b000, 3'b100, 1'b0, 1'b0);
        add("t3_start",   5'b00000, 2'd0, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t3_midcall", 5'b01000, 2'd0, 3'b100, 3'b110, 1'b0, 1'b0);
        add("t3_stop1",   5'b00000, 2'd1, 3'b001, 3'b100, 1'b0, 1'b0);
        add("t3_dwell1",  5'b00000, 2'd1, 3'b001, 3'b100, 1'b0, 1'b0);
        add("t3_dwell2",  5'b00000, 2'd1, 3'b001, 3'b100, 1'b0, 1'b0);
        add("t3_resume",  5'b00000, 2'd1, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t3_trav",    5'b00000, 2'd1, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t3_stop2",   5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t3_dwell3",  5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t3_dwell4",  5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t3_close",   5'b00000, 2'd2, 3'b000, 3'b000, 1'b0, 1'b0);
        // Overload: weight high for 10 cycles holds the door, then 3-cycle dwell.
        add("t5_open",    5'b00101, 2'd2, 3'b001, 3'b000, 1'b0, 1'b1);
        for (int k = 0; k < 9; k++) begin
            add("t5_hold", 5'b00001, 2'd2, 3'b001, 3'b000, 1'b0, 1'b1);
        end
        add("t5_release", 5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t5_dwell",   5'b00000, 2'd2, 3'b001, 3'b000, 1'b0, 1'b0);
        add("t5_close",   5'b00000, 2'd2, 3'b000, 3'b000, 1'b0, 1'b0);
        // Return to 00, passing 01 without stopping.
        add("r_call0",    5'b10000, 2'd2, 3'b000, 3'b001, 1'b0, 1'b0);
        add("r_start",    5'b00000, 2'd2, 3'b010, 3'b001, 1'b0, 1'b0);
        add("r_trav",     5'b00000, 2'd2, 3'b010, 3'b001, 1'b0, 1'b0);
        add("r_pass1",    5'b00000, 2'd1, 3'b010, 3'b001, 1'b0, 1'b0);
        add("r_trav2",    5'b00000, 2'd1, 3'b010, 3'b001, 1'b0, 1'b0);
        add("r_arrive0",  5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("r_dwell1",   5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("r_dwell2",   5'b00000, 2'd0, 3'b001, 3'b000, 1'b0, 1'b0);
        add("r_close",    5'b00000, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        // SOS mid-transit 00->01: calls ignored, held SOS inert, second edge exits.
        add("t6_press",   5'b00100, 2'd0, 3'b000, 3'b100, 1'b0, 1'b0);
        add("t6_start",   5'b00000, 2'd0, 3'b100, 3'b100, 1'b0, 1'b0);
        add("t6_sos",     5'b01010, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        add("t6_held",    5'b11110, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        add("t6_btn",     5'b00100, 2'd0, 3'b000, 3'b000, 1'b1, 1'b0);
        add("t6_exit",    5'b00110, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);
        add("t6_idle",    5'b00000, 2'd0, 3'b000, 3'b000, 1'b0, 1'b0);

        #12;
        check("reset_state", obs, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < vecs.size(); k++) begin
            @(negedge clk);
            drive(vecs[k].in);
            sb.push_back(vecs[k]);
            @(posedge clk);
            #1;
            begin
                vec_t v;
                v = sb.pop_front();
                check(v.name, obs, v.exp);
            end
        end

        // Asynchronous reset mid-transit (car at 00, dir up after SOS sequence).
        @(negedge clk);
        drive(5'b00100);
        @(negedge clk);
        drive(5'b00000);
        @(negedge clk);
        #2;
        check("ra_moving", obs, {2'd0, 3'b100, 3'b100, 1'b0, 1'b0});
        rst_n = 1'b0;
        #1;
        check("ra_async", obs, 10'b0);
        @(posedge clk);
        #1;
        check("ra_hold", obs, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Asynchronous reset mid-dwell.
        drive(5'b10000);
        @(posedge clk);
        #1;
        check("rb_door", obs, {2'd0, 3'b001, 3'b000, 1'b0, 1'b0});
        @(negedge clk);
        drive(5'b00000);
        #2;
        rst_n = 1'b0;
        #1;
        check("rb_async", obs, 10'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rb_after", obs, 10'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
